sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one external 16-bit asynchronous SRAM between two CPU requesters.
// Port A is read-only (instruction fetch); port B reads or writes (data).
// Each access runs through a fixed IDLE -> SETUP -> STROBE(xWAIT_CYCLES) -> DONE
// sequence. Contention is resolved round-robin. All pin outputs are registered.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   aReq/aAddr      port A read request (level, held until aAck) and word address
//   aAck/aData      port A one-cycle completion pulse and read data (held)
//   bReq/bWrite     port B request (held until bAck) and write select
//   bAddr/bWdata    port B word address and write data
//   bAck/bRdata     port B one-cycle completion pulse and read data (held)
//   memDataBus      SRAM data bus (driven only during writes)
//   memAddrBus      SRAM address, upper two bits always zero
//   memRead/Write/Enable  SRAM OE_n / WE_n / CE_n
//   busy            high whenever an access is in progress

module sram_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1  // STROBE length in cycles, 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aReq,
    input  logic [15:0] aAddr,
    output logic        aAck,
    output logic [15:0] aData,
    input  logic        bReq,
    input  logic        bWrite,
    input  logic [15:0] bAddr,
    input  logic [15:0] bWdata,
    output logic        bAck,
    output logic [15:0] bRdata,
    inout  wire  [15:0] memDataBus,
    output logic [17:0] memAddrBus,
    output logic        memRead,
    output logic        memWrite,
    output logic        memEnable,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StDone
    } state_e;

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;  // 0 = A, 1 = B
    logic        sel_b_q, sel_b_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic [15:0] a_data_q, a_data_d;
    logic [15:0] b_rdata_q, b_rdata_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ce_n_q, ce_n_d;
    logic        drive_q, drive_d;
    logic        busy_q, busy_d;

    logic        grant_a, grant_b;
    logic        in_access;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        sel_b_d      = sel_b_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        a_data_d     = a_data_q;
        b_rdata_d    = b_rdata_q;
        grant_a      = 1'b0;
        grant_b      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (aReq && bReq) begin
                    // Contention: favour the port that was not served last.
                    grant_b = ~last_grant_q;
                    grant_a = last_grant_q;
                end else begin
                    grant_a = aReq;
                    grant_b = bReq;
                end
                if (grant_a || grant_b) begin
                    state_d      = StSetup;
                    sel_b_d      = grant_b;
                    write_d      = grant_b & bWrite;
                    addr_d       = grant_b ? bAddr : aAddr;
                    wdata_d      = bWdata;
                    last_grant_d = grant_b;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = WaitInit;
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    // Capture read data on the edge that leaves STROBE.
                    if (!write_q) begin
                        if (sel_b_q) begin
                            b_rdata_d = memDataBus;
                        end else begin
                            a_data_d = memDataBus;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so the pins line up with it.
        in_access = (state_d == StSetup) || (state_d == StStrobe);
        ce_n_d    = ~in_access;
        oe_n_d    = ~(in_access && !write_d);
        we_n_d    = ~((state_d == StStrobe) && write_d);
        drive_d   = write_d && (state_d != StIdle);
        a_ack_d   = (state_d == StDone) && !sel_b_d;
        b_ack_d   = (state_d == StDone) && sel_b_d;
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b0;
            sel_b_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 16'd0;
            wdata_q      <= 16'd0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_data_q     <= 16'd0;
            b_rdata_q    <= 16'd0;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            ce_n_q       <= 1'b1;
            drive_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            sel_b_q      <= sel_b_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_data_q     <= a_data_d;
            b_rdata_q    <= b_rdata_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            ce_n_q       <= ce_n_d;
            drive_q      <= drive_d;
            busy_q       <= busy_d;
        end
    end

    assign memDataBus = drive_q ? wdata_q : 16'hzzzz;
    assign memAddrBus = {2'b00, addr_q};
    assign memRead    = oe_n_q;
    assign memWrite   = we_n_q;
    assign memEnable  = ce_n_q;
    assign aAck       = a_ack_q;
    assign bAck       = b_ack_q;
    assign aData      = a_data_q;
    assign bRdata     = b_rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one instance at WAIT_CYCLES=1 and one
// at WAIT_CYCLES=2, each attached to a small behavioural SRAM. The data buses
// carry pull-ups so an undriven bus reads as 16'hFFFF.

module tb_sram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    // Instance 1, WAIT_CYCLES = 1
    logic        a_req1, b_req1, b_write1;
    logic [15:0] a_addr1, b_addr1, b_wdata1;
    logic        a_ack1, b_ack1;
    logic [15:0] a_data1, b_rdata1;
    wire  [15:0] mem_bus1;
    logic [17:0] mem_addr1;
    logic        mem_rd1, mem_wr1, mem_en1, busy1;

    // Instance 2, WAIT_CYCLES = 2
    logic        a_req2, b_req2, b_write2;
    logic [15:0] a_addr2, b_addr2, b_wdata2;
    logic        a_ack2, b_ack2;
    logic [15:0] a_data2, b_rdata2;
    wire  [15:0] mem_bus2;
    logic [17:0] mem_addr2;
    logic        mem_rd2, mem_wr2, mem_en2, busy2;

    sram_port_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .aReq(a_req1), .aAddr(a_addr1), .aAck(a_ack1), .aData(a_data1),
        .bReq(b_req1), .bWrite(b_write1), .bAddr(b_addr1), .bWdata(b_wdata1),
        .bAck(b_ack1), .bRdata(b_rdata1),
        .memDataBus(mem_bus1), .memAddrBus(mem_addr1),
        .memRead(mem_rd1), .memWrite(mem_wr1), .memEnable(mem_en1), .busy(busy1)
    );

    sram_port_arbiter #(.WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .aReq(a_req2), .aAddr(a_addr2), .aAck(a_ack2), .aData(a_data2),
        .bReq(b_req2), .bWrite(b_write2), .bAddr(b_addr2), .bWdata(b_wdata2),
        .bAck(b_ack2), .bRdata(b_rdata2),
        .memDataBus(mem_bus2), .memAddrBus(mem_addr2),
        .memRead(mem_rd2), .memWrite(mem_wr2), .memEnable(mem_en2), .busy(busy2)
    );

    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup (mem_bus1[i]);
        pullup (mem_bus2[i]);
    end

    // Behavioural SRAMs
    logic [15:0] sram1 [0:65535];
    logic [15:0] sram2 [0:65535];
    logic        pl_we1;
    logic [15:0] pl_addr1, pl_data1;

    assign mem_bus1 = (!mem_en1 && !mem_rd1) ? sram1[mem_addr1[15:0]] : 16'hzzzz;
    assign mem_bus2 = (!mem_en2 && !mem_rd2) ? sram2[mem_addr2[15:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (pl_we1) sram1[pl_addr1] <= pl_data1;
        if (!mem_en1 && !mem_wr1) sram1[mem_addr1[15:0]] <= mem_bus1;
    end

    always @(posedge clk) begin
        if (!mem_en2 && !mem_wr2) sram2[mem_addr2[15:0]] <= mem_bus2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload1(input logic [15:0] addr, input logic [15:0] data);
        pl_addr1 = addr;
        pl_data1 = data;
        pl_we1   = 1'b1;
        @(negedge clk);
        pl_we1   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_req1 = 0; b_req1 = 0; b_write1 = 0; a_addr1 = 0; b_addr1 = 0; b_wdata1 = 0;
        a_req2 = 0; b_req2 = 0; b_write2 = 0; a_addr2 = 0; b_addr2 = 0; b_wdata2 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_lo, rd_lo, we_lo, drv, ack_cnt, ack_at, first_we, other_ack;
        int n_g, overlap, longp, n_ack, last_k, d1, d2, first_grant;
        logic [3:0] seq;
        logic rearm_a, rearm_b, prev_a, prev_b;

        rst = 1'b1;
        pl_we1 = 1'b0; pl_addr1 = 0; pl_data1 = 0;
        do_reset();

        // Reset state
        check("rst_busy", busy1, 0);
        check("rst_en", mem_en1, 1);
        check("rst_rd", mem_rd1, 1);
        check("rst_wr", mem_wr1, 1);
        check("rst_addr", mem_addr1, 0);
        check("rst_acks", {a_ack1, b_ack1}, 0);
        check("rst_data", {a_data1, b_rdata1}, 0);
        check("rst_bus_z", mem_bus1, 16'hFFFF);

        // Single read on port A, W=1
        preload1(16'h0010, 16'hBEEF);
        a_addr1 = 16'h0010;
        a_req1  = 1'b1;
        en_lo = 0; rd_lo = 0; ack_cnt = 0; ack_at = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!mem_en1) en_lo++;
            if (!mem_rd1) rd_lo++;
            if (k == 0) check("rdA_addr", mem_addr1, 18'h00010);
            if (a_ack1) begin
                ack_cnt++;
                ack_at = k;
                a_req1 = 1'b0;
                check("rdA_data_done", a_data1, 16'hBEEF);
            end
        end
        check("rdA_en_cycles", en_lo, 2);
        check("rdA_rd_cycles", rd_lo, 2);
        check("rdA_ack_count", ack_cnt, 1);
        check("rdA_ack_cycle", ack_at, 2);
        check("rdA_data_held", a_data1, 16'hBEEF);
        check("rdA_idle", busy1, 0);

        // Port B write, W=2
        do_reset();
        b_write2 = 1'b1;
        b_addr2  = 16'h1234;
        b_wdata2 = 16'hA5A5;
        b_req2   = 1'b1;
        we_lo = 0; drv = 0; rd_lo = 0; ack_cnt = 0; ack_at = -1; first_we = -1;
        other_ack = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!mem_wr2) begin
                we_lo++;
                if (first_we < 0) first_we = k;
            end
            if (mem_bus2 == 16'hA5A5) drv++;
            if (!mem_rd2) rd_lo++;
            if (a_ack2) other_ack++;
            if (b_ack2) begin
                ack_cnt++;
                ack_at = k;
                b_req2 = 1'b0;
            end
        end
        check("wrB_we_cycles", we_lo, 2);
        check("wrB_we_first", first_we, 1);
        check("wrB_bus_cycles", drv, 4);
        check("wrB_bus_released", mem_bus2, 16'hFFFF);
        check("wrB_oe_never", rd_lo, 0);
        check("wrB_ack_count", ack_cnt, 1);
        check("wrB_ack_cycle", ack_at, 3);
        check("wrB_no_aack", other_ack, 0);
        check("wrB_sram", sram2[16'h1234], 16'hA5A5);
        check("wrB_rdata_kept", b_rdata2, 16'h0000);
        check("wrB_adata_kept", a_data2, 16'h0000);
        check("wrB_idle", busy2, 0);

        // Contention: B, A, B, A
        do_reset();
        preload1(16'h0100, 16'hAAAA);
        preload1(16'h0200, 16'hBBBB);
        a_addr1 = 16'h0100;
        b_addr1 = 16'h0200;
        a_req1 = 1'b1;
        b_req1 = 1'b1;
        seq = 4'b0000; n_g = 0; overlap = 0; longp = 0;
        rearm_a = 0; rearm_b = 0; prev_a = 0; prev_b = 0;
        for (int k = 0; k < 60 && n_g < 4; k++) begin
            @(negedge clk);
            if (rearm_a) begin a_req1 = 1'b1; rearm_a = 1'b0; end
            if (rearm_b) begin b_req1 = 1'b1; rearm_b = 1'b0; end
            if (a_ack1 && b_ack1) overlap++;
            if ((a_ack1 && prev_a) || (b_ack1 && prev_b)) longp++;
            prev_a = a_ack1;
            prev_b = b_ack1;
            if (a_ack1) begin
                if (n_g < 4) seq[n_g] = 1'b0;
                n_g++;
                a_req1 = 1'b0;
                rearm_a = 1'b1;
                check("cont_adata", a_data1, 16'hAAAA);
            end
            if (b_ack1) begin
                if (n_g < 4) seq[n_g] = 1'b1;
                n_g++;
                b_req1 = 1'b0;
                rearm_b = 1'b1;
                check("cont_bdata", b_rdata1, 16'hBBBB);
            end
        end
        a_req1 = 1'b0;
        b_req1 = 1'b0;
        check("cont_grants", n_g, 4);
        check("cont_order", seq, 4'b0101);
        check("cont_overlap", overlap, 0);
        check("cont_pulse_width", longp, 0);
        repeat (6) @(negedge clk);

        // Back-to-back A reads, W=1
        do_reset();
        a_addr1 = 16'h0010;
        a_req1  = 1'b1;
        n_ack = 0; last_k = 0; d1 = 0; d2 = 0; longp = 0; prev_a = 0;
        for (int k = 0; k < 30 && n_ack < 3; k++) begin
            @(negedge clk);
            if (a_ack1 && prev_a) longp++;
            prev_a = a_ack1;
            if (a_ack1) begin
                if (n_ack == 1) d1 = k - last_k;
                if (n_ack == 2) d2 = k - last_k;
                last_k = k;
                n_ack++;
            end
        end
        a_req1 = 1'b0;
        check("b2b_acks", n_ack, 3);
        check("b2b_gap1", d1, 4);
        check("b2b_gap2", d2, 4);
        check("b2b_pulse_width", longp, 0);
        repeat (6) @(negedge clk);

        // Reset in the middle of a port B write
        do_reset();
        b_write1 = 1'b1;
        b_addr1  = 16'h0300;
        b_wdata1 = 16'h5A5A;
        b_req1   = 1'b1;
        @(negedge clk);
        check("rstw_setup_we", mem_wr1, 1);
        check("rstw_setup_bus", mem_bus1, 16'h5A5A);
        @(negedge clk);
        check("rstw_strobe_we", {mem_wr1, mem_en1}, 2'b00);
        #1 rst = 1'b1;
        #1;
        check("rstw_async_pins", {mem_wr1, mem_en1, mem_rd1}, 3'b111);
        check("rstw_bus_z", mem_bus1, 16'hFFFF);
        check("rstw_busy", busy1, 0);
        b_req1 = 1'b0;
        b_write1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (b_ack1 || a_ack1) ack_cnt++;
        end
        check("rstw_no_ack", ack_cnt, 0);
        a_addr1 = 16'h0100;
        b_addr1 = 16'h0200;
        a_req1 = 1'b1;
        b_req1 = 1'b1;
        first_grant = -1;
        for (int k = 0; k < 10 && first_grant < 0; k++) begin
            @(negedge clk);
            if (b_ack1) first_grant = 1;
            else if (a_ack1) first_grant = 0;
        end
        a_req1 = 1'b0;
        b_req1 = 1'b0;
        check("rstw_next_grant_b", first_grant, 1);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
